// File: rtl/async_fifo_pkg.sv
// Shared pointer-encoding helpers for the Gray-pointer FIFO.
package async_fifo_pkg;

    // Widest pointer the helpers support; narrower pointers are zero-extended.
    localparam int unsigned MAX_PTR_W = 16;

    typedef logic [MAX_PTR_W-1:0] ptr_t;

    // Binary to reflected Gray code.
    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    // Reflected Gray code to binary; leading zeros from zero-extension are harmless.
    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b = g;
        for (int unsigned i = 1; i < MAX_PTR_W; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// Two-flop synchroniser for a Gray-coded pointer crossing to the other side.
module fifo_ptr_sync #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First stage may go metastable once the sides are split; second stage resolves it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/async_fifo.sv
// FIFO with Gray-coded pointers exchanged through synchronisers; single clock for now.
module async_fifo
    import async_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = 8,
    parameter int unsigned FIFO_DEPTH_WIDTH = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        write,
    input  logic [DATA_WIDTH-1:0]       data_write,
    input  logic                        read,
    output logic [DATA_WIDTH-1:0]       data_read,
    output logic                        full,
    output logic                        empty,
    output logic [FIFO_DEPTH_WIDTH-1:0] data_count_w,
    output logic [FIFO_DEPTH_WIDTH-1:0] data_count_r
);

    localparam int unsigned PW    = FIFO_DEPTH_WIDTH;
    localparam int unsigned DEPTH = 1 << PW;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wptr, rptr;
    logic [PW-1:0] wptr_gray, rptr_gray;
    logic [PW-1:0] wq2_wptr, rq2_rptr;
    logic [PW-1:0] wq2_bin, rq2_bin;
    logic [PW-1:0] wptr_inc, rptr_inc;
    logic          write_en, read_en;

    // Write pointer seen by the read side, and read pointer seen by the write side.
    fifo_ptr_sync #(.WIDTH(PW)) u_wptr_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (wptr_gray),
        .q     (wq2_wptr)
    );

    fifo_ptr_sync #(.WIDTH(PW)) u_rptr_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rptr_gray),
        .q     (rq2_rptr)
    );

    // Flags and counts from registered pointers; synchronised views are decoded first.
    always_comb begin
        wq2_bin      = PW'(gray2bin(ptr_t'(wq2_wptr)));
        rq2_bin      = PW'(gray2bin(ptr_t'(rq2_rptr)));
        wptr_inc     = wptr + PW'(1);
        rptr_inc     = rptr + PW'(1);
        full         = (wptr_inc == rq2_bin);
        empty        = (wq2_bin == rptr);
        data_count_w = wptr - rq2_bin;
        data_count_r = wq2_bin - rptr;
        write_en     = write & ~full;
        read_en      = read & ~empty;
    end

    // Write-side pointer and its Gray copy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr      <= '0;
            wptr_gray <= '0;
        end else if (write_en) begin
            wptr      <= wptr_inc;
            wptr_gray <= PW'(bin2gray(ptr_t'(wptr_inc)));
        end
    end

    // Read-side pointer, its Gray copy and the registered read data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rptr      <= '0;
            rptr_gray <= '0;
            data_read <= '0;
        end else if (read_en) begin
            rptr      <= rptr_inc;
            rptr_gray <= PW'(bin2gray(ptr_t'(rptr_inc)));
            data_read <= mem[rptr];
        end
    end

    // Storage is not reset; the one-slot gap keeps write and read slots distinct.
    always_ff @(posedge clk) begin
        if (rst_n && write_en) begin
            mem[wptr] <= data_write;
        end
    end

endmodule

// File: tb/tb_async_fifo.sv
// Scoreboard bench for async_fifo with a cycle model of the two-edge pointer latency.
module tb_async_fifo;

    localparam int unsigned DW  = 8;
    localparam int unsigned AW  = 5;
    localparam int          CAP = (1 << AW) - 1;

    logic          clk;
    logic          rst_n;
    logic          write;
    logic [DW-1:0] data_write;
    logic          read;
    logic [DW-1:0] data_read;
    logic          full;
    logic          empty;
    logic [AW-1:0] data_count_w;
    logic [AW-1:0] data_count_r;

    async_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH_WIDTH(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .write        (write),
        .data_write   (data_write),
        .read         (read),
        .data_read    (data_read),
        .full         (full),
        .empty        (empty),
        .data_count_w (data_count_w),
        .data_count_r (data_count_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: total words written/read plus their two-edge-delayed views.
    int            mw, mw_d1, mw_d2;
    int            mr, mr_d1, mr_d2;
    logic [DW-1:0] sb_q [$];
    logic [DW-1:0] exp_data;
    bit            saw_full;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_full();
        return (mw - mr_d2) == CAP;
    endfunction

    function automatic bit model_empty();
        return mw_d2 == mr;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".full"},  32'(full),         32'(model_full()));
        check({tag, ".empty"}, 32'(empty),        32'(model_empty()));
        check({tag, ".cnt_w"}, 32'(data_count_w), 32'((mw - mr_d2) & CAP));
        check({tag, ".cnt_r"}, 32'(data_count_r), 32'((mw_d2 - mr) & CAP));
        check({tag, ".data"},  32'(data_read),    32'(exp_data));
    endtask

    // One clock: drive inputs, advance the model across the edge, compare #1 later.
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input string tag);
        bit wa, ra;
        wa = w && !model_full();
        ra = r && !model_empty();
        write      = w;
        data_write = d;
        read       = r;
        @(posedge clk);
        mw_d2 = mw_d1; mw_d1 = mw;
        mr_d2 = mr_d1; mr_d1 = mr;
        if (wa) begin
            sb_q.push_back(d);
            mw++;
        end
        if (ra) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL %s.underflow: model read with empty scoreboard", tag);
            end else begin
                exp_data = sb_q.pop_front();
            end
            mr++;
        end
        #1;
        if (full) saw_full = 1'b1;
        check_all(tag);
    endtask

    task automatic do_reset(input int edges);
        write      = 1'b0;
        read       = 1'b0;
        data_write = '0;
        rst_n      = 1'b0;
        repeat (edges) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mw = 0; mw_d1 = 0; mw_d2 = 0;
        mr = 0; mr_d1 = 0; mr_d2 = 0;
        sb_q.delete();
        exp_data = '0;
        check("rst.empty", 32'(empty),        32'd1);
        check("rst.full",  32'(full),         32'd0);
        check("rst.cnt_w", 32'(data_count_w), 32'd0);
        check("rst.cnt_r", 32'(data_count_r), 32'd0);
        check("rst.data",  32'(data_read),    32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        write      = 1'b0;
        read       = 1'b0;
        data_write = '0;
        saw_full   = 1'b0;

        do_reset(2);

        // Fill beyond capacity: 0..30 accepted, 31..40 dropped.
        for (int i = 0; i <= 40; i++) step(1'b1, DW'(i), 1'b0, "fill");
        check("fill.full_end",  32'(full),         32'd1);
        check("fill.cnt_w_end", 32'(data_count_w), 32'd31);
        step(1'b0, '0, 1'b0, "fill_idle");
        step(1'b0, '0, 1'b0, "fill_idle");
        check("fill.cnt_r_end", 32'(data_count_r), 32'd31);

        // Drain with extra reads past empty.
        for (int i = 0; i < 41; i++) step(1'b0, '0, 1'b1, "drain");
        check("drain.last",  32'(data_read),    32'd30);
        check("drain.empty", 32'(empty),        32'd1);
        check("drain.cnt_r", 32'(data_count_r), 32'd0);
        step(1'b0, '0, 1'b0, "drain_idle");
        step(1'b0, '0, 1'b0, "drain_idle");
        check("drain.cnt_w", 32'(data_count_w), 32'd0);

        // Latency of a single word through to the read side.
        step(1'b1, 8'hA5, 1'b0, "lat_k");
        check("lat.cnt_w_k", 32'(data_count_w), 32'd1);
        check("lat.empty_k", 32'(empty),        32'd1);
        step(1'b0, '0, 1'b0, "lat_k1");
        check("lat.empty_k1", 32'(empty), 32'd1);
        step(1'b0, '0, 1'b0, "lat_k2");
        check("lat.empty_k2", 32'(empty), 32'd0);
        step(1'b0, '0, 1'b1, "lat_rd");
        check("lat.data", 32'(data_read), 32'hA5);
        step(1'b0, '0, 1'b0, "lat_idle");
        step(1'b0, '0, 1'b0, "lat_idle");

        // Streaming with read held high.
        saw_full = 1'b0;
        for (int i = 0; i <= 50; i++) step(1'b1, DW'(i), 1'b1, "stream");
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, "stream_tail");
        check("stream.last",     32'(data_read), 32'd50);
        check("stream.no_full",  32'(saw_full),  32'd0);
        check("stream.empty",    32'(empty),     32'd1);
        check("stream.sb_empty", 32'(sb_q.size()), 32'd0);

        // Reset with data stored; stale words must not reappear.
        for (int i = 0; i < 10; i++) step(1'b1, DW'(8'hE0 + i), 1'b0, "pre_rst");
        step(1'b0, '0, 1'b0, "pre_rst_idle");
        step(1'b0, '0, 1'b0, "pre_rst_idle");
        do_reset(1);
        step(1'b1, 8'h3C, 1'b0, "post_rst_wr");
        step(1'b0, '0, 1'b0, "post_rst_idle");
        step(1'b0, '0, 1'b0, "post_rst_idle");
        step(1'b0, '0, 1'b1, "post_rst_rd");
        check("post_rst.data", 32'(data_read), 32'h3C);
        step(1'b0, '0, 1'b1, "post_rst_rd2");
        check("post_rst.hold", 32'(data_read), 32'h3C);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/async_fifo.md
Name: async_fifo

Overview:
Parameterised FIFO buffer with separate write-side and read-side interfaces. Internally it uses Gray-coded pointers exchanged through 2-flop synchronisers, so it can later be split into two clock domains. In this block both sides run on one clock. It buffers byte streams between a producer and a slower consumer, with per-side occupancy counts and full/empty flags.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- FIFO_DEPTH_WIDTH, 5, address width; storage is 2^FIFO_DEPTH_WIDTH words; usable capacity is 2^FIFO_DEPTH_WIDTH−1 (31 at default).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- write  input  1  write request.
- data_write  input  DATA_WIDTH  word to store.
- read  input  1  read request.
- data_read  output  DATA_WIDTH  registered read data.
- full  output  1  write side is full.
- empty  output  1  read side is empty.
- data_count_w  output  FIFO_DEPTH_WIDTH  occupancy as seen by the write side.
- data_count_r  output  FIFO_DEPTH_WIDTH  occupancy as seen by the read side.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - Clears binary and Gray pointers and all synchroniser flops.
  - data_read=0, empty=1, full=0, both counts 0.
  - Memory contents need not be cleared; previously stored data is discarded.
  - Reset mid-operation is handled identically.
- Pointers: wptr and rptr are FIFO_DEPTH_WIDTH-bit binary counters that wrap modulo 2^W. Each has a registered Gray copy (g = b ^ (b>>1)).
- Synchronisers:
  - wptr_gray passes through 2 flops to give wq2_wptr (read side).
  - rptr_gray passes through 2 flops to give rq2_rptr (write side).
  - Synchronised values are converted Gray→binary before any arithmetic.
- Write accept = write & ~full. On an accepted write, mem[wptr] <= data_write and wptr increments. A write while full is ignored with no state change.
- Read accept = read & ~empty. On an accepted read, data_read <= mem[rptr] and rptr increments. A read while empty is ignored and data_read holds its value.
- Flags and counts are combinational from registered pointers:
  - full = ((wptr+1) mod 2^W) == bin(rq2_rptr)
  - empty = bin(wq2_wptr) == rptr
  - data_count_w = wptr − bin(rq2_rptr) mod 2^W
  - data_count_r = bin(wq2_wptr) − rptr mod 2^W
- Latency: a write accepted at edge k is visible to the read side after edge k+2 (empty falls, data_count_r increments). A read accepted at edge k frees space on the write side after edge k+2. Both flags are therefore conservative, never optimistic.
- Simultaneous accepted read and write in the same cycle are both performed. The memory read and the memory write never target the same slot.
- data_read changes only on an accepted read or on reset.
- Order is strictly preserved. There is no duplication and no loss of accepted words.

Decomposition:
- Package async_fifo_pkg: bin2gray and gray2bin functions, parameterised on width.
- One sub-module, fifo_ptr_sync: 2-flop pointer synchroniser with synchronous active-low reset, parameterised on width. It is instantiated twice.
- Memory array and pointer logic stay in the top module.

Test Plan:
- Reset: hold rst_n=0 for 2 edges → empty=1, full=0, data_count_w=data_count_r=0, data_read=0.
- Fill: write=1 with data 0..40 on consecutive cycles, read=0 → words 0..30 accepted; full=1 right after the 31st accepted write; data_count_w=31; words 31..40 dropped; after 2 more edges data_count_r=31.
- Drain: read=1 for 41 cycles → data_read sequence 0..30; empty=1 after the 31st read; the extra reads leave data_read=30; data_count_r=0, and data_count_w=0 two edges later.
- Latency: from empty, a single write of 0xA5 at edge k → data_count_w=1 after edge k; empty stays 1 after edges k and k+1 and falls after edge k+2; a read then returns 0xA5.
- Streaming: read held at 1 while writing 0..50 on consecutive cycles → data_read emits 0..50 in order with no gaps or duplicates; full never asserts; the FIFO ends empty.
- Mid-operation reset: with 10 words stored, pull rst_n low for 1 edge → empty=1, counts 0, data_read=0; a following write/read pair returns the new word, not stale data.
